// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported Wishbone-style memory between the
// instruction-fetch port and the load/store data port. A registered FSM grants
// one requester per transaction, and data is preferred unless fetch has already
// waited through STARVE_LIMIT back-to-back data grants.
// Optional feature macro: MEM_ARB_TIMEOUT_EN aborts a memory cycle that gets no
// i_mem_ack within TIMEOUT_CYC cycles and flags it on o_ierr/o_derr.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_istb,
  input  logic [AW-1:0]   i_iaddr,
  output logic            o_iack,
  output logic [DW-1:0]   o_inst,
  input  logic            i_dstb,
  input  logic            i_dwe,
  input  logic [AW-1:0]   i_daddr,
  input  logic [DW-1:0]   i_dwdata,
  input  logic [DW/8-1:0] i_dsel,
  output logic            o_dack,
  output logic [DW-1:0]   o_drdata,
  output logic            o_mem_stb,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_sel,
  input  logic            i_mem_ack,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_ierr,
  output logic            o_derr,
  output logic            o_busy
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 4;

  // Reject parameter values outside the supported ranges at elaboration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("mem_port_arbiter: STARVE_LIMIT or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IGNT = 2'd1,
    ST_DGNT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   starve_q,    starve_d;
  logic            abandon_q,   abandon_d;
  logic            mem_stb_q,   mem_stb_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]   mem_sel_q,   mem_sel_d;
  logic            iack_q,      iack_d;
  logic            dack_q,      dack_d;
  logic [DW-1:0]   inst_q,      inst_d;
  logic [DW-1:0]   drdata_q,    drdata_d;
  logic            busy_q,      busy_d;
  logic            owner_stb;
  logic            abandon_now;
  logic            starve_full;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0] NOP_INST = DW'(32'h0000_0013);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ierr_q, ierr_d;
  logic          derr_q, derr_d;
`endif

  assign starve_full = (starve_q == CW'(STARVE_LIMIT));

  // Next-state, request latching and response generation.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    abandon_d   = abandon_q;
    mem_stb_d   = mem_stb_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    inst_d      = inst_q;
    drdata_d    = drdata_q;
    owner_stb   = (state_q == ST_IGNT) ? i_istb : i_dstb;
    abandon_now = abandon_q | ~owner_stb;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    ierr_d      = 1'b0;
    derr_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        abandon_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d     = '0;
`endif
        if (!i_istb) begin
          starve_d = '0;
        end
        if (i_dstb && !(starve_full && i_istb)) begin
          state_d     = ST_DGNT;
          mem_stb_d   = 1'b1;
          mem_we_d    = i_dwe;
          mem_addr_d  = i_daddr;
          mem_wdata_d = i_dwdata;
          mem_sel_d   = i_dsel;
          // Below the limit here whenever fetch is waiting, so no overflow.
          if (i_istb) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (i_istb) begin
          state_d    = ST_IGNT;
          mem_stb_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_iaddr;
          mem_sel_d  = '1;
          starve_d   = '0;
        end
      end

      ST_IGNT, ST_DGNT: begin
        // A requester that drops stb mid-cycle forfeits its response.
        abandon_d = abandon_now;
        if (i_mem_ack) begin
          state_d   = ST_RESP;
          mem_stb_d = 1'b0;
          if (!abandon_now) begin
            if (state_q == ST_IGNT) begin
              iack_d = 1'b1;
              inst_d = i_mem_rdata;
            end else begin
              dack_d   = 1'b1;
              drdata_d = i_mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_RESP;
          mem_stb_d = 1'b0;
          if (!abandon_now) begin
            if (state_q == ST_IGNT) begin
              iack_d = 1'b1;
              ierr_d = 1'b1;
              inst_d = NOP_INST;
            end else begin
              dack_d   = 1'b1;
              derr_d   = 1'b1;
              drdata_d = '0;
            end
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      abandon_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      inst_q      <= '0;
      drdata_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      abandon_q   <= abandon_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      inst_q      <= inst_d;
      drdata_q    <= drdata_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog counter and error flags for aborted memory cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q  <= '0;
      ierr_q <= 1'b0;
      derr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      ierr_q <= ierr_d;
      derr_q <= derr_d;
    end
  end

  assign o_ierr = ierr_q;
  assign o_derr = derr_q;
`else
  assign o_ierr = 1'b0;
  assign o_derr = 1'b0;
`endif

  assign o_iack      = iack_q;
  assign o_inst      = inst_q;
  assign o_dack      = dack_q;
  assign o_drdata    = drdata_q;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_sel   = mem_sel_q;
  assign o_busy      = busy_q;

endmodule
